// File: rtl/cache_controller.sv
// Sequencing controller for a 4-way, 8-set write-back data cache.
// One CPU request at a time: lookup, LRU victim choice, dirty writeback, refill, respond.
// Also keeps the read/write hit/miss statistics counters.
module cache_controller #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 8,
  parameter int unsigned LINE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       read_hit,
  output logic [31:0]       read_miss,
  output logic [31:0]       write_hit,
  output logic [31:0]       write_miss
);

  localparam int unsigned WordW = $clog2(LINE_W);
  localparam int unsigned SetW  = $clog2(SETS);
  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned TagW  = ADDR_W - SetW - WordW - 2;
  localparam int unsigned ReqW  = ADDR_W - 2;

  localparam logic [WordW-1:0] LastBeat  = WordW'(LINE_W - 1);
  localparam logic [WayW-1:0]  OldestAge = WayW'(WAYS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StRespond
  } state_e;

  typedef logic [SETS-1:0][WAYS-1:0][WayW-1:0] age_arr_t;

  // Ages start as way w = w so every set holds a permutation of 0..WAYS-1.
  function automatic age_arr_t ages_at_reset();
    age_arr_t a;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        a[s][w] = WayW'(w);
      end
    end
    return a;
  endfunction

  state_e state_q, state_d;

  // Latched request; byte-offset bits are not kept.
  logic [ReqW-1:0]   req_addr_q;
  logic              req_we_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              first_q;
  logic [WayW-1:0]   victim_q;
  logic [WordW-1:0]  beat_q;
  logic [DATA_W-1:0] rdata_q;

  logic [31:0] read_hit_q, read_miss_q, write_hit_q, write_miss_q;

  // Line metadata and storage.
  logic [SETS-1:0][WAYS-1:0][TagW-1:0] tag_q;
  logic [SETS-1:0][WAYS-1:0]           valid_q;
  logic [SETS-1:0][WAYS-1:0]           dirty_q;
  age_arr_t                            age_q;
  logic [DATA_W-1:0]                   data_q [SETS][WAYS][LINE_W];

  logic [TagW-1:0]  req_tag;
  logic [SetW-1:0]  req_set;
  logic [WordW-1:0] req_word;

  logic            hit;
  logic [WayW-1:0] hit_way;
  logic [WayW-1:0] hit_age;
  logic            free_found;
  logic [WayW-1:0] victim;
  logic            victim_dirty;

  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign req_word = req_addr_q[WordW-1:0];
  assign req_set  = req_addr_q[WordW +: SetW];
  assign req_tag  = req_addr_q[ReqW-1 -: TagW];

  assign read_hit   = read_hit_q;
  assign read_miss  = read_miss_q;
  assign write_hit  = write_hit_q;
  assign write_miss = write_miss_q;

  // Tag compare across the ways of the requested set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
    hit_age = age_q[req_set][hit_way];
  end

  // Victim: lowest-index invalid way, otherwise the oldest way of the set.
  always_comb begin
    free_found = 1'b0;
    victim     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!free_found && !valid_q[req_set][w]) begin
        free_found = 1'b1;
        victim     = WayW'(w);
      end
    end
    if (!free_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_set][w] == OldestAge) begin
          victim = WayW'(w);
        end
      end
    end
    victim_dirty = valid_q[req_set][victim] & dirty_q[req_set][victim];
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        cpu_ready = 1'b1;
        if (cpu_req) begin
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          state_d = StRespond;
        end else if (victim_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StRefill;
        end
      end
      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_set][victim_q], req_set, beat_q, 2'b00};
        mem_wdata = data_q[req_set][victim_q][beat_q];
        if (mem_ack && (beat_q == LastBeat)) begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_set, beat_q, 2'b00};
        if (mem_ack && (beat_q == LastBeat)) begin
          state_d = StLookup;
        end
      end
      StRespond: begin
        cpu_done = 1'b1;
        if (!req_we_q) begin
          cpu_rdata = rdata_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, victim/beat tracking and read data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      first_q     <= 1'b0;
      victim_q    <= '0;
      beat_q      <= '0;
      rdata_q     <= '0;
    end else begin
      if ((state_q == StIdle) && cpu_req) begin
        req_addr_q  <= cpu_addr[ADDR_W-1:2];
        req_we_q    <= cpu_we;
        req_wdata_q <= cpu_wdata;
        first_q     <= 1'b1;
      end
      if (state_q == StLookup) begin
        first_q <= 1'b0;
        if (hit) begin
          rdata_q <= data_q[req_set][hit_way][req_word];
        end else begin
          victim_q <= victim;
          beat_q   <= '0;
        end
      end
      // Beat counter wraps to 0 on the last beat, ready for the next phase.
      if (((state_q == StWriteback) || (state_q == StRefill)) && mem_ack) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Statistics: only the first lookup of a request counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_hit_q   <= '0;
      read_miss_q  <= '0;
      write_hit_q  <= '0;
      write_miss_q <= '0;
    end else if ((state_q == StLookup) && first_q) begin
      unique case ({req_we_q, hit})
        2'b01:   read_hit_q   <= read_hit_q + 32'd1;
        2'b00:   read_miss_q  <= read_miss_q + 32'd1;
        2'b11:   write_hit_q  <= write_hit_q + 32'd1;
        default: write_miss_q <= write_miss_q + 32'd1;
      endcase
    end
  end

  // Tag/valid/dirty/LRU maintenance.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      age_q   <= ages_at_reset();
    end else begin
      if ((state_q == StLookup) && hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[req_set][w] < hit_age) begin
            age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
          end
        end
        age_q[req_set][hit_way] <= '0;
        if (req_we_q) begin
          dirty_q[req_set][hit_way] <= 1'b1;
        end
      end
      if ((state_q == StRefill) && mem_ack && (beat_q == LastBeat)) begin
        tag_q[req_set][victim_q]   <= req_tag;
        valid_q[req_set][victim_q] <= 1'b1;
        dirty_q[req_set][victim_q] <= 1'b0;
      end
    end
  end

  // Line data: write hits and refill beats; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((state_q == StLookup) && hit && req_we_q) begin
        data_q[req_set][hit_way][req_word] <= req_wdata_q;
      end else if ((state_q == StRefill) && mem_ack) begin
        data_q[req_set][victim_q][beat_q] <= mem_rdata;
      end
    end
  end

endmodule
